// File: rtl/veripac_bus_master.sv
// Host-side initiator for the VeriPac 8-bit peripheral bus: turns block write,
// block read and step commands into registered bus_wr/bus_rd/bus_step cycles.
module veripac_bus_master #(
  parameter int unsigned RD_WAIT   = 1,
  parameter int unsigned STEP_HIGH = 2,
  parameter int unsigned STEP_LOW  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_len,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic [7:0] bus_addr,
  output logic       bus_rd,
  output logic       bus_wr,
  output logic [7:0] bus_dout,
  input  logic [7:0] bus_din,
  output logic       bus_step,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_WAIT,
    S_WR_STROBE,
    S_RD_ADDR,
    S_RD_HOLD,
    S_STEP_HI,
    S_STEP_LO,
    S_DONE
  } state_t;

  localparam logic [7:0] RD_LOAD  = 8'(RD_WAIT - 1);
  localparam logic [7:0] HI_LOAD  = 8'(STEP_HIGH - 1);
  localparam logic [7:0] LO_LOAD  = 8'(STEP_LOW - 1);

  state_t     r_state;
  logic [7:0] r_addr;
  logic [8:0] r_count;
  logic [7:0] r_tmr;
  logic       r_cmd_ready;
  logic       r_rd_valid;
  logic [7:0] r_rd_data;
  logic [7:0] r_bus_addr;
  logic       r_bus_rd;
  logic       r_bus_wr;
  logic [7:0] r_bus_dout;
  logic       r_bus_step;
  logic       r_busy;
  logic       r_done;

  logic [8:0] w_len;
  logic [7:0] w_addr_nxt;
  logic       w_last;

  // A length of zero encodes a full 256-item block.
  assign w_len      = {(cmd_len == 8'd0), cmd_len};
  assign w_addr_nxt = r_addr + 8'd1;
  assign w_last     = (r_count == 9'd1);

  assign wr_ready  = (r_state == S_WR_WAIT) && wr_valid;
  assign cmd_ready = r_cmd_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign bus_addr  = r_bus_addr;
  assign bus_rd    = r_bus_rd;
  assign bus_wr    = r_bus_wr;
  assign bus_dout  = r_bus_dout;
  assign bus_step  = r_bus_step;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_count     <= '0;
      r_tmr       <= '0;
      r_cmd_ready <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_bus_addr  <= '0;
      r_bus_rd    <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_dout  <= '0;
      r_bus_step  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= cmd_addr;
            r_count     <= w_len;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            case (cmd_op)
              2'b00: r_state <= S_WR_WAIT;
              2'b01: begin
                r_state    <= S_RD_ADDR;
                r_bus_rd   <= 1'b1;
                r_bus_addr <= cmd_addr;
                r_tmr      <= RD_LOAD;
              end
              2'b10: begin
                r_state    <= S_STEP_HI;
                r_bus_step <= 1'b1;
                r_tmr      <= HI_LOAD;
              end
              default: begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            endcase
          end
        end

        S_WR_WAIT: begin
          if (wr_valid) begin
            r_state    <= S_WR_STROBE;
            r_bus_wr   <= 1'b1;
            r_bus_addr <= r_addr;
            r_bus_dout <= wr_data;
          end
        end

        S_WR_STROBE: begin
          r_bus_wr <= 1'b0;
          r_addr   <= w_addr_nxt;
          r_count  <= r_count - 9'd1;
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_WR_WAIT;
          end
        end

        S_RD_ADDR: begin
          if (r_tmr == 8'd0) begin
            r_rd_data  <= bus_din;
            r_bus_rd   <= 1'b0;
            r_rd_valid <= 1'b1;
            r_state    <= S_RD_HOLD;
          end else begin
            r_tmr <= r_tmr - 8'd1;
          end
        end

        // bus_rd stays low here so the core is free to run between reads.
        S_RD_HOLD: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
            r_addr     <= w_addr_nxt;
            r_count    <= r_count - 9'd1;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_RD_ADDR;
              r_bus_rd   <= 1'b1;
              r_bus_addr <= w_addr_nxt;
              r_tmr      <= RD_LOAD;
            end
          end
        end

        S_STEP_HI: begin
          if (r_tmr == 8'd0) begin
            r_state    <= S_STEP_LO;
            r_bus_step <= 1'b0;
            r_tmr      <= LO_LOAD;
          end else begin
            r_tmr <= r_tmr - 8'd1;
          end
        end

        S_STEP_LO: begin
          if (r_tmr == 8'd0) begin
            r_count <= r_count - 9'd1;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_STEP_HI;
              r_bus_step <= 1'b1;
              r_tmr      <= HI_LOAD;
            end
          end else begin
            r_tmr <= r_tmr - 8'd1;
          end
        end

        S_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_veripac_bus_master.sv
// Directed bench for veripac_bus_master with a small VeriPac memory/step model.
module tb_veripac_bus_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [7:0] bus_addr;
  logic       bus_rd;
  logic       bus_wr;
  logic [7:0] bus_dout;
  logic [7:0] bus_din;
  logic       bus_step;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  veripac_bus_master #(
    .RD_WAIT  (1),
    .STEP_HIGH(2),
    .STEP_LOW (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .bus_addr (bus_addr),
    .bus_rd   (bus_rd),
    .bus_wr   (bus_wr),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .bus_step (bus_step),
    .busy     (busy),
    .done     (done)
  );

  // VeriPac model: byte memory, read port, step edge counter.
  logic [7:0]  mem [256];
  logic [7:0]  wbuf [256];
  logic [7:0]  st_addr [$];
  logic [7:0]  st_data [$];
  int unsigned st_cyc [$];
  int unsigned acc_q [$];
  int unsigned cyc, pc, done_cnt, done_cyc, viol, dbl;
  logic        step_d, done_d;
  int unsigned n_chk, n_err;

  assign bus_din = bus_rd ? mem[bus_addr] : 8'h00;

  always @(posedge clk) begin
    if (bus_wr) begin
      mem[bus_addr] = bus_dout;
      st_addr.push_back(bus_addr);
      st_data.push_back(bus_dout);
      st_cyc.push_back(cyc);
    end
    if (bus_step && !step_d) pc++;
    step_d = bus_step;
    if ((bus_rd && bus_wr) || (bus_step && (bus_rd || bus_wr))) viol++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (done && done_d) dbl++;
    done_d = done;
    if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] l);
    int k;
    cmd_op = op; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin tick(); k++; end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin tick(); k++; end
    chk(tag, done, 1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] l, input int budget);
    int idx, k;
    logic hs;
    idx = 0; k = 0;
    wr_data = wbuf[0];
    wr_valid = 1'b1;
    issue_cmd(2'b00, a, l);
    while (!done && k < budget) begin
      hs = wr_ready;
      tick();
      k++;
      if (hs) idx++;
      wr_data = wbuf[idx & 255];
    end
    chk("wr_done", done, 1);
    wr_valid = 1'b0;
  endtask

  task automatic wait_rd(input string tag);
    int k;
    k = 0;
    while (!rd_valid && k < 20) begin tick(); k++; end
    chk(tag, rd_valid, 1);
  endtask

  initial begin
    int unsigned dc0, pc0, bad;
    logic [7:0] exp_rd [4];
    n_chk = 0; n_err = 0; cyc = 0; pc = 0; done_cnt = 0; viol = 0; dbl = 0;
    step_d = 1'b0; done_d = 1'b0;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; wbuf[i] = 8'h00; end
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_len = 8'h00;
    wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bus", {bus_rd, bus_wr, bus_step, done, rd_valid}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    reset = 1'b0;
    tick();

    // Write block 0x10, len 3
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
    st_addr.delete(); st_data.delete(); st_cyc.delete();
    dc0 = done_cnt;
    do_write(8'h10, 8'd3, 40);
    chk("t1_busy_in_done", busy, 1);
    tick();
    chk("t1_done_cnt", done_cnt - dc0, 1);
    chk("t1_idle_ready", {cmd_ready, busy, done}, 3'b100);
    chk("t1_strobes", st_addr.size(), 3);
    for (int i = 0; i < 3 && i < st_addr.size(); i++) begin
      chk("t1_addr", st_addr[i], 8'h10 + 8'(i));
      chk("t1_data", st_data[i], wbuf[i]);
      if (i > 0) chk("t1_gap", st_cyc[i] - st_cyc[i-1], 2);
    end
    chk("t1_mem", {mem[8'h10], mem[8'h11], mem[8'h12]}, 24'hAABBCC);

    // Read block 0xFE, len 4 with a 5-cycle stall on byte 2
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;
    issue_cmd(2'b01, 8'hFE, 8'd4);
    for (int b = 0; b < 4; b++) begin
      wait_rd("t2_rd_valid");
      if (b == 1) begin
        for (int s = 0; s < 5; s++) begin
          chk("t2_stall_data", rd_data, 8'h22);
          chk("t2_stall_rd_low", bus_rd, 0);
          tick();
        end
      end
      chk("t2_rd_data", rd_data, exp_rd[b]);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      chk("t2_rd_valid_drop", rd_valid, 0);
    end
    wait_done("t2_done", 10);
    tick();

    // Step len 3: 1,1,0,0 x3 then done
    pc0 = pc;
    issue_cmd(2'b10, 8'h00, 8'd3);
    for (int i = 0; i < 12; i++) begin
      chk("t3_step_pat", bus_step, ((i % 4) < 2) ? 1 : 0);
      tick();
    end
    chk("t3_done_after_low", done, 1);
    tick();
    chk("t3_pc_adv", pc - pc0, 3);

    // Write len 0 -> 256 strobes starting at 0x40
    for (int i = 0; i < 256; i++) wbuf[i] = 8'(i) ^ 8'h5A;
    st_addr.delete(); st_data.delete(); st_cyc.delete();
    dc0 = done_cnt;
    do_write(8'h40, 8'd0, 700);
    tick();
    chk("t4_strobes", st_addr.size(), 256);
    bad = 0;
    for (int i = 0; i < st_addr.size(); i++)
      if (st_addr[i] != 8'(8'h40 + 8'(i)) || st_data[i] != wbuf[i]) bad++;
    chk("t4_seq_bad", bad, 0);
    if (st_addr.size() == 256) chk("t4_last_addr", st_addr[255], 8'h3F);
    chk("t4_bus_addr_hold", bus_addr, 8'h3F);
    chk("t4_done_cnt", done_cnt - dc0, 1);

    // Reset during byte 2 of a 4-byte write
    st_addr.delete(); st_data.delete(); st_cyc.delete();
    wr_data = 8'h01; wr_valid = 1'b1;
    issue_cmd(2'b00, 8'h80, 8'd4);
    begin
      int k;
      k = 0;
      while (!(bus_wr && st_addr.size() == 1) && k < 20) begin tick(); k++; end
      chk("t5_reach_byte2", bus_wr, 1);
    end
    #2 reset = 1'b1;
    #1;
    chk("t5_wr_async", bus_wr, 0);
    chk("t5_ready_async", {cmd_ready, busy}, 2'b10);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (10) tick();
    chk("t5_no_more_strobes", st_addr.size(), 1);
    chk("t5_idle", {cmd_ready, busy, bus_wr}, 3'b100);
    wr_valid = 1'b0;

    // Back-to-back commands with cmd_valid held
    st_addr.delete(); st_data.delete(); st_cyc.delete(); acc_q.delete();
    pc0 = pc;
    wr_valid = 1'b1; wr_data = 8'h77;
    cmd_op = 2'b00; cmd_addr = 8'h20; cmd_len = 8'd1; cmd_valid = 1'b1;
    tick();
    cmd_op = 2'b10; cmd_len = 8'd1;
    begin
      int k;
      k = 0;
      while (acc_q.size() < 2 && k < 40) begin tick(); k++; end
    end
    cmd_valid = 1'b0;
    chk("t6_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("t6_accept_gap", acc_q[1] - acc_q[0], 4);
      chk("t6_after_done", acc_q[1] - done_cyc, 1);
    end
    chk("t6_wr_ready_ignored", wr_ready, 0);
    wr_valid = 1'b0;
    wait_done("t6_step_done", 20);
    tick();
    chk("t6_strobe", {st_addr.size() == 1, mem[8'h20]}, {1'b1, 8'h77});
    chk("t6_pc_adv", pc - pc0, 1);

    chk("bus_overlap", viol, 0);
    chk("done_width", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/veripac_bus_master.md
Name: veripac_bus_master

Overview:
- Host-side initiator for the VeriPac 8-bit peripheral bus (addr/rd/wr/din/dout/step/reset).
- Accepts block commands from the ZX-Uno control logic and issues the matching bus cycles:
  - block write of program/RAM/register bytes from a byte stream;
  - block read of RAM, screen or registers into a byte stream;
  - N clean step pulses.
- Sits between the host command/stream logic and the VeriPac core.

Parameters:
- RD_WAIT, 1: cycles bus_rd is held high before bus_din is sampled (≥1).
- STEP_HIGH, 2: cycles bus_step is high per pulse (≥1).
- STEP_LOW, 2: cycles bus_step is low after each pulse (≥1). Guarantees a rising edge for the core's edge detector.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- cmd_valid, input, 1: command offered.
- cmd_ready, output, 1: master idle and accepting a command.
- cmd_op, input, 2: operation. 00 = write block, 01 = read block, 10 = step, 11 = reserved.
- cmd_addr, input, 8: start bus address (ignored for step).
- cmd_len, input, 8: byte count or pulse count; 0 means 256.
- wr_valid, input, 1: write byte available.
- wr_data, input, 8: write byte.
- wr_ready, output, 1: write byte accepted this cycle.
- rd_valid, output, 1: read byte available.
- rd_data, output, 8: read byte.
- rd_ready, input, 1: consumer accepts read byte.
- bus_addr, output, 8: VeriPac addr.
- bus_rd, output, 1: VeriPac rd.
- bus_wr, output, 1: VeriPac wr.
- bus_dout, output, 8: VeriPac din.
- bus_din, input, 8: VeriPac dout.
- bus_step, output, 1: VeriPac step.
- busy, output, 1: command in progress.
- done, output, 1: one-cycle pulse on command completion.

Behaviour:
- Reset (asynchronous, immediate): state IDLE.
  - All outputs 0 except cmd_ready = 1.
  - Internal address and count cleared.
- General output rules:
  - All bus outputs are registered.
  - bus_rd and bus_wr are never high together.
  - bus_step is never high while bus_rd or bus_wr is high.
- IDLE: cmd_ready = 1, busy = 0.
  - On cmd_valid: latch op, addr and count (0 → 256); cmd_ready drops the next cycle; busy = 1.
  - Op 11: no bus activity. done pulses the cycle after acceptance, then return to IDLE.
- WR_WAIT: wr_ready = wr_valid (combinational).
  - On handshake, go to WR_STROBE.
- WR_STROBE: one cycle with bus_wr = 1, bus_addr = current addr, bus_dout = accepted byte.
  - Then addr += 1 (mod 256, FF wraps to 00) and count -= 1.
  - count 0 → DONE; otherwise → WR_WAIT.
  - Throughput: 2 cycles per byte minimum; wr_valid gaps stall in WR_WAIT with no bus strobes.
- RD_ADDR: bus_rd = 1 and bus_addr = current addr for RD_WAIT cycles.
  - On the last cycle, rd_data ← bus_din.
  - Next cycle: bus_rd = 0, rd_valid = 1, state RD_HOLD.
- RD_HOLD: rd_valid and rd_data held stable until rd_ready.
  - On rd_ready: rd_valid drops the next cycle; addr += 1 (wraps); count -= 1.
  - count 0 → DONE; otherwise → RD_ADDR.
  - bus_rd stays low while waiting, so the core can run between reads.
- STEP_HI: bus_step = 1 for STEP_HIGH cycles → STEP_LO.
- STEP_LO: bus_step = 0 for STEP_LOW cycles. Then count -= 1.
  - count 0 → DONE; otherwise → STEP_HI.
  - During stepping, bus_rd = bus_wr = 0.
- DONE: done = 1 for exactly one cycle; busy = 0 from the next cycle → IDLE.
  - cmd_ready rises in the cycle after DONE, so back-to-back commands have ≥1 idle cycle.
- bus_addr after a command: holds the last driven value until the next bus cycle.
- Reset mid-command: everything aborts immediately; the partial transfer is not completed.
  - bus_wr, bus_rd and bus_step fall asynchronously.
- Inputs ignored outside their own phase:
  - wr_valid outside WR_WAIT is ignored (wr_ready = 0).
  - rd_ready outside RD_HOLD is ignored.

Test Plan:
- Write block addr=0x10, len=3, bytes AA, BB, CC with wr_valid always high → exactly three 1-cycle bus_wr strobes at 0x10/0x11/0x12 with the correct data, each separated by one low cycle. done pulses once; a VeriPac model reads back AA, BB, CC.
- Read block addr=0xFE, len=4 from a model holding 0xFE=11, 0xFF=22, 0x00=33, 0x01=44, with rd_ready stalled 5 cycles on the second byte → stream 11, 22, 33, 44 in order (address wraps FF→00). rd_data stays stable during the stall; bus_rd is low during the stall.
- Step len=3, STEP_HIGH=2, STEP_LOW=2 → bus_step pattern 1,1,0,0 repeated 3 times (12 cycles). The model's programCounter advances by exactly 3. done follows the last low phase.
- Write len=0 → exactly 256 strobes, address wraps to the start value, then done.
- Assert reset during byte 2 of a 4-byte write → bus_wr low immediately. cmd_ready = 1 and busy = 0 after release. No further strobes occur.
- Two commands with cmd_valid held high (write len=1, then step len=1) → second accepted only after done and a cmd_ready cycle. Bus activity never overlaps between commands.
